tnn_feature_loader: RTL and testbench
=====================================

TNN_FEATURE_LOADER -- requirements
Module: tnn_feature_loader

Interface
REQ-001 Parameter FEAT_CNT, default 11, is the number of features per sample.
REQ-002 Parameter FEAT_BITS, default 4, is the width of each feature.
REQ-003 Parameter CLASS_CNT, default 7, is the number of classes; CLS_W = $clog2(CLASS_CNT).
REQ-004 Parameter SETTLE_CYCLES, default 2, is the classifier settle time in clocks; legal range 1..15.
REQ-005 Port clk, input, 1 bit, is the single clock; all logic is on its rising edge.
REQ-006 Port rst_n, input, 1 bit, is the asynchronous, active-low reset.
REQ-007 Port s_valid, input, 1 bit, means the upstream feature beat is valid.
REQ-008 Port s_ready, output, 1 bit, means the loader accepts a feature beat.
REQ-009 Port s_feat, input, FEAT_BITS bits, carries one feature per beat.
REQ-010 Port features, output, FEAT_CNT*FEAT_BITS bits, is the packed vector driven to the combinational classifier.
REQ-011 Port prediction, input, CLS_W bits, is the classifier result.
REQ-012 Port m_valid, output, 1 bit, means a result is held on m_class.
REQ-013 Port m_ready, input, 1 bit, means downstream accepts the result.
REQ-014 Port m_class, output, CLS_W bits, is the captured prediction.
REQ-015 Port sample_cnt, output, 16 bits, counts results accepted downstream.

Function
REQ-016 The FSM SHALL have exactly three states: LOAD, SETTLE and HOLD.
REQ-017 In LOAD, s_ready SHALL be 1 and m_valid SHALL be 0.
REQ-018 A beat SHALL be accepted only on a clock where s_valid=1 and s_ready=1.
REQ-019 Beat k (0-based) of a sample SHALL be written to features[(FEAT_CNT-k)*FEAT_BITS-1 -: FEAT_BITS], so the first beat lands in the most significant field (hex-file order).
REQ-020 The beat index SHALL wrap to 0 after the beat with index FEAT_CNT-1 is accepted, and the FSM SHALL then enter SETTLE.
REQ-021 In SETTLE and HOLD, s_ready SHALL be 0 and features SHALL remain stable.
REQ-022 SETTLE SHALL last exactly SETTLE_CYCLES clocks, counted by a down-counter.
REQ-023 On the last SETTLE clock, m_class SHALL be loaded with prediction and the FSM SHALL enter HOLD.
REQ-024 Latency from acceptance of the last beat to m_valid=1 SHALL be SETTLE_CYCLES+1 clocks.
REQ-025 In HOLD, m_valid SHALL be 1 and m_class SHALL be stable until the handshake completes.
REQ-026 The handshake SHALL complete on a clock where m_valid=1 and m_ready=1.
REQ-027 On handshake completion, sample_cnt SHALL increment, wrapping from 0xFFFF to 0, and the FSM SHALL return to LOAD.
REQ-028 s_ready SHALL not be asserted in the HOLD-to-LOAD transition clock, so there is no overlap of the next sample with the current result.
REQ-029 features SHALL retain the previous sample's unwritten fields until they are overwritten; no clear between samples.
REQ-030 A prediction value of CLASS_CNT or greater SHALL be passed through unmodified.

Reset
REQ-031 While rst_n=0, the state SHALL be LOAD, the beat index 0, the settle counter 0, features all zeros, m_class 0, m_valid 0 and sample_cnt 0; s_ready SHALL be 1 once rst_n=1.
REQ-032 Reset asserted mid-sample or in HOLD SHALL discard partial or pending data with no downstream handshake.

Structure
REQ-033 Package tnn_pkg SHALL hold the state enum type (LOAD, SETTLE, HOLD) and the default FEAT_CNT, FEAT_BITS and CLASS_CNT constants.
REQ-034 The classifier SHALL be instantiated outside this block; no sub-module is required inside it.

Verification
REQ-035 Eleven back-to-back beats 0x1..0xB SHALL yield features=0x123456789AB and, with prediction=3, m_valid=1 after 3 clocks with m_class=3.
REQ-036 With s_valid toggled every other clock, exactly 11 beats SHALL be accepted, the same vector SHALL result, and no beat SHALL be lost or duplicated.
REQ-037 With m_ready=0 for 10 clocks in HOLD, m_valid and m_class SHALL stay stable, s_ready SHALL stay 0 and sample_cnt SHALL stay unchanged; m_ready=1 SHALL then increment sample_cnt by 1.
REQ-038 Asserting rst_n=0 after beat 5 SHALL reset all outputs to 0 immediately, and a subsequent full sample SHALL pack from field 0.
REQ-039 Starting from sample_cnt=0xFFFF, one completed result SHALL produce sample_cnt=0x0000.
REQ-040 A prediction that changes during SETTLE SHALL be captured at the value present on the last SETTLE clock.

Source files
------------

// File: rtl/tnn_pkg.sv
// Shared types and default sizing for the TNN feature loader.
// The state enum is kept here so the loader and any wrappers agree on encodings.
package tnn_pkg;

    localparam int DEF_FEAT_CNT  = 11;
    localparam int DEF_FEAT_BITS = 4;
    localparam int DEF_CLASS_CNT = 7;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/tnn_feature_loader.sv
// Serial-to-parallel feature loader for an external combinational TNN classifier.
// Streams one feature per beat, waits for the classifier to settle, then holds its result for downstream.
module tnn_feature_loader
    import tnn_pkg::*;
#(
    parameter int FEAT_CNT      = DEF_FEAT_CNT,
    parameter int FEAT_BITS     = DEF_FEAT_BITS,
    parameter int CLASS_CNT     = DEF_CLASS_CNT,
    parameter int SETTLE_CYCLES = 2,
    localparam int CLS_W        = $clog2(CLASS_CNT)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [FEAT_BITS-1:0]          s_feat,
    output logic [FEAT_CNT*FEAT_BITS-1:0] features,
    input  logic [CLS_W-1:0]              prediction,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [CLS_W-1:0]              m_class,
    output logic [15:0]                   sample_cnt
);

    localparam int IDX_W    = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
    localparam int SETTLE_W = 4;

    state_t                        state_reg;
    state_t                        state_next;
    logic [IDX_W-1:0]              idx_reg;
    logic [SETTLE_W-1:0]           settle_reg;
    logic [FEAT_CNT*FEAT_BITS-1:0] features_reg;
    logic [CLS_W-1:0]              m_class_reg;
    logic [15:0]                   sample_cnt_reg;

    logic beat_fire;
    logic last_beat;
    logic settle_done;
    logic result_fire;

    assign last_beat   = (idx_reg == IDX_W'(FEAT_CNT - 1));
    assign settle_done = (state_reg == SETTLE) && (settle_reg == '0);

    // s_ready and m_valid come purely from the state, so the handshake clock
    // out of HOLD never exposes s_ready=1 alongside the outgoing result.
    always_comb begin
        state_next  = state_reg;
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        beat_fire   = 1'b0;
        result_fire = 1'b0;
        case (state_reg)
            LOAD: begin
                s_ready   = 1'b1;
                beat_fire = s_valid;
                if (s_valid && last_beat) begin
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_reg == '0) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                m_valid     = 1'b1;
                result_fire = m_ready;
                if (m_ready) begin
                    state_next = LOAD;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= LOAD;
            idx_reg        <= '0;
            settle_reg     <= '0;
            features_reg   <= '0;
            m_class_reg    <= '0;
            sample_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;

            if (beat_fire) begin
                idx_reg <= last_beat ? '0 : idx_reg + 1'b1;
            end

            // Beat k lands in field FEAT_CNT-1-k; untouched fields keep the previous sample.
            for (int i = 0; i < FEAT_CNT; i++) begin
                if (beat_fire && (idx_reg == IDX_W'(FEAT_CNT - 1 - i))) begin
                    features_reg[i*FEAT_BITS +: FEAT_BITS] <= s_feat;
                end
            end

            if (beat_fire && last_beat) begin
                settle_reg <= SETTLE_W'(SETTLE_CYCLES - 1);
            end else if ((state_reg == SETTLE) && (settle_reg != '0)) begin
                settle_reg <= settle_reg - 1'b1;
            end

            if (settle_done) begin
                m_class_reg <= prediction;
            end

            if (result_fire) begin
                sample_cnt_reg <= sample_cnt_reg + 16'd1;
            end
        end
    end

    assign features   = features_reg;
    assign m_class    = m_class_reg;
    assign sample_cnt = sample_cnt_reg;

endmodule

// File: tb/tb_tnn_feature_loader.sv
// Directed self-checking bench for tnn_feature_loader with default parameters.
// Each scenario task drives its stimulus and checks hand-computed expectations inline.
module tb_tnn_feature_loader;

    localparam int FEAT_CNT  = 11;
    localparam int FEAT_BITS = 4;
    localparam int CLS_W     = 3;
    localparam int FW        = FEAT_CNT * FEAT_BITS;

    logic              clk;
    logic              rst_n;
    logic              s_valid;
    logic              s_ready;
    logic [3:0]        s_feat;
    logic [FW-1:0]     features;
    logic [CLS_W-1:0]  prediction;
    logic              m_valid;
    logic              m_ready;
    logic [CLS_W-1:0]  m_class;
    logic [15:0]       sample_cnt;

    int checks   = 0;
    int failures = 0;

    tnn_feature_loader #(
        .FEAT_CNT      (FEAT_CNT),
        .FEAT_BITS     (FEAT_BITS),
        .CLASS_CNT     (7),
        .SETTLE_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_feat     (s_feat),
        .features   (features),
        .prediction (prediction),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_class    (m_class),
        .sample_cnt (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one beat for one clock; DUT is expected to be in LOAD.
    task automatic send_beat(input logic [3:0] v);
        s_valid = 1'b1;
        s_feat  = v;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({features, m_valid, m_class, sample_cnt} !== {{FW{1'b0}}, 1'b0, 3'd0, 16'd0}) begin
            failures++;
            $display("FAIL reset_outputs: features=%h m_valid=%b m_class=%0d sample_cnt=%h expected all zero",
                     features, m_valid, m_class, sample_cnt);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_s_ready: got %b expected 1", s_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_back_to_back();
        prediction = 3'd3;
        for (int i = 0; i < FEAT_CNT; i++) begin
            checks++;
            if (s_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_s_ready beat %0d: got %b expected 1", i, s_ready);
            end
            send_beat(4'(i + 1));
        end
        checks++;
        if (features !== 44'h123456789AB) begin
            failures++;
            $display("FAIL b2b_features: got %h expected 123456789ab", features);
        end
        checks++;
        if ({s_ready, m_valid} !== 2'b00) begin
            failures++;
            $display("FAIL b2b_settle1: s_ready=%b m_valid=%b expected 0 0", s_ready, m_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({s_ready, m_valid} !== 2'b00) begin
            failures++;
            $display("FAIL b2b_settle2: s_ready=%b m_valid=%b expected 0 0", s_ready, m_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({m_valid, m_class} !== {1'b1, 3'd3}) begin
            failures++;
            $display("FAIL b2b_result: m_valid=%b m_class=%0d expected 1 3", m_valid, m_class);
        end
        m_ready = 1'b1;
        checks++;
        if (s_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_handshake_s_ready: got %b expected 0", s_ready);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        checks++;
        if ({m_valid, s_ready, sample_cnt} !== {1'b0, 1'b1, 16'd1}) begin
            failures++;
            $display("FAIL b2b_after_hs: m_valid=%b s_ready=%b sample_cnt=%h expected 0 1 0001",
                     m_valid, s_ready, sample_cnt);
        end
        $display("test_back_to_back done sample_cnt=%0d", sample_cnt);
    endtask

    task automatic test_retention_and_capture();
        logic [3:0] vals [FEAT_CNT];
        for (int i = 0; i < FEAT_CNT; i++) vals[i] = 4'(15 - i);
        prediction = 3'd1;
        for (int i = 0; i < 4; i++) send_beat(vals[i]);
        checks++;
        if (features !== 44'hFEDC56789AB) begin
            failures++;
            $display("FAIL retention_partial: got %h expected fedc56789ab", features);
        end
        for (int i = 4; i < FEAT_CNT; i++) send_beat(vals[i]);
        checks++;
        if (features !== 44'hFEDCBA98765) begin
            failures++;
            $display("FAIL retention_full: got %h expected fedcba98765", features);
        end
        prediction = 3'd5;
        @(posedge clk);
        #1;
        prediction = 3'd7;
        @(posedge clk);
        #1;
        prediction = 3'd0;
        checks++;
        if ({m_valid, m_class} !== {1'b1, 3'd7}) begin
            failures++;
            $display("FAIL capture_last_settle: m_valid=%b m_class=%0d expected 1 7", m_valid, m_class);
        end
        @(posedge clk);
        #1;
        checks++;
        if (m_class !== 3'd7) begin
            failures++;
            $display("FAIL capture_stable: m_class=%0d expected 7", m_class);
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        checks++;
        if (sample_cnt !== 16'd2) begin
            failures++;
            $display("FAIL retention_count: sample_cnt=%h expected 0002", sample_cnt);
        end
        $display("test_retention_and_capture done m_class=%0d", m_class);
    endtask

    task automatic test_gapped();
        int n = 0;
        int cyc = 0;
        prediction = 3'd2;
        while (n < FEAT_CNT && cyc < 60) begin
            if (cyc % 2 == 0) begin
                s_valid = 1'b1;
                s_feat  = 4'(n + 1);
            end else begin
                s_valid = 1'b0;
                s_feat  = 4'h0;
            end
            @(posedge clk);
            if (s_valid && s_ready) n++;
            #1;
            cyc++;
        end
        s_valid = 1'b0;
        checks++;
        if (n != FEAT_CNT) begin
            failures++;
            $display("FAIL gapped_timeout: accepted %0d beats expected %0d", n, FEAT_CNT);
        end
        checks++;
        if (s_ready !== 1'b0) begin
            failures++;
            $display("FAIL gapped_stop: s_ready=%b expected 0 after 11 beats", s_ready);
        end
        checks++;
        if (features !== 44'h123456789AB) begin
            failures++;
            $display("FAIL gapped_features: got %h expected 123456789ab", features);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({m_valid, m_class} !== {1'b1, 3'd2}) begin
            failures++;
            $display("FAIL gapped_result: m_valid=%b m_class=%0d expected 1 2", m_valid, m_class);
        end
        $display("test_gapped done accepted=%0d in %0d clocks", n, cyc);
    endtask

    task automatic test_hold_stall();
        m_ready = 1'b0;
        prediction = 3'd4;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({m_valid, m_class, s_ready, sample_cnt, features} !==
                {1'b1, 3'd2, 1'b0, 16'd2, 44'h123456789AB}) begin
                failures++;
                $display("FAIL hold_stall clk %0d: m_valid=%b m_class=%0d s_ready=%b cnt=%h feat=%h expected 1 2 0 0002 123456789ab",
                         i, m_valid, m_class, s_ready, sample_cnt, features);
            end
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        checks++;
        if ({sample_cnt, m_valid, s_ready} !== {16'd3, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL hold_release: cnt=%h m_valid=%b s_ready=%b expected 0003 0 1",
                     sample_cnt, m_valid, s_ready);
        end
        $display("test_hold_stall done sample_cnt=%0d", sample_cnt);
    endtask

    task automatic test_reset_mid();
        logic [3:0] vals [FEAT_CNT];
        vals = '{4'h3, 4'h1, 4'h4, 4'h1, 4'h5, 4'h9, 4'h2, 4'h6, 4'h5, 4'h3, 4'h5};
        for (int i = 0; i < 5; i++) send_beat(4'(10 + i));
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({features, m_valid, m_class, sample_cnt} !== {{FW{1'b0}}, 1'b0, 3'd0, 16'd0}) begin
            failures++;
            $display("FAIL mid_reset: features=%h m_valid=%b m_class=%0d cnt=%h expected all zero",
                     features, m_valid, m_class, sample_cnt);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        prediction = 3'd6;
        for (int i = 0; i < FEAT_CNT; i++) send_beat(vals[i]);
        checks++;
        if (features !== 44'h31415926535) begin
            failures++;
            $display("FAIL mid_reset_repack: got %h expected 31415926535", features);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({m_valid, m_class} !== {1'b1, 3'd6}) begin
            failures++;
            $display("FAIL mid_reset_result: m_valid=%b m_class=%0d expected 1 6", m_valid, m_class);
        end
        // Reset while HOLD with m_ready high must drop the result without counting it.
        m_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_valid, sample_cnt} !== {1'b0, 16'd0}) begin
            failures++;
            $display("FAIL hold_reset: m_valid=%b cnt=%h expected 0 0000", m_valid, sample_cnt);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        checks++;
        if ({sample_cnt, s_ready} !== {16'd0, 1'b1}) begin
            failures++;
            $display("FAIL hold_reset_after: cnt=%h s_ready=%b expected 0000 1", sample_cnt, s_ready);
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_count_wrap();
        prediction = 3'd1;
        for (int i = 0; i < FEAT_CNT; i++) send_beat(4'h0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({m_valid, m_class, features} !== {1'b1, 3'd1, {FW{1'b0}}}) begin
            failures++;
            $display("FAIL wrap_result: m_valid=%b m_class=%0d features=%h expected 1 1 0",
                     m_valid, m_class, features);
        end
        force dut.sample_cnt_reg = 16'hFFFF;
        #1;
        release dut.sample_cnt_reg;
        #1;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        checks++;
        if ({sample_cnt, m_valid} !== {16'h0000, 1'b0}) begin
            failures++;
            $display("FAIL count_wrap: cnt=%h m_valid=%b expected 0000 0", sample_cnt, m_valid);
        end
        $display("test_count_wrap done sample_cnt=%h", sample_cnt);
    endtask

    initial begin
        rst_n      = 1'b0;
        s_valid    = 1'b0;
        s_feat     = 4'h0;
        prediction = 3'd0;
        m_ready    = 1'b0;
        test_reset();
        test_back_to_back();
        test_retention_and_capture();
        test_gapped();
        test_hold_stall();
        test_reset_mid();
        test_count_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
